decode_stage: RTL

Parametrised instruction-decode pipeline stage for the 20-bit pipelined processor. It sits between instruction fetch and execute. It registers the decoded instruction into an ID/EX register under a valid/ready handshake. It generates register-file read addresses, with the store-specific operand mapping, plus destination and control flags. It inserts a one-cycle bubble on load-use hazards and supports a synchronous flush from branch resolution.

---
 rtl/decode_pkg.sv | 21 ++
 rtl/decode_fields.sv | 39 +++
 rtl/decode_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared opcode constants and the decoded-fields record for the 20-bit pipeline decode stage.
package decode_pkg;

  localparam int DEF_OPC_W  = 4;
  localparam int DEF_REG_AW = 4;

  localparam logic [DEF_OPC_W-1:0] STORE = 4'b1100;
  localparam logic [DEF_OPC_W-1:0] LOAD  = 4'b1011;
  localparam logic [DEF_OPC_W-1:0] NOP   = 4'b0000;

  // Register-address fields are sized for the default REG_AW of the processor.
  typedef struct packed {
    logic [DEF_REG_AW-1:0] raddr1;
    logic [DEF_REG_AW-1:0] raddr2;
    logic [DEF_REG_AW-1:0] dest;
    logic                  isLoad;
    logic                  isStore;
    logic                  writesReg;
  } decodedFields_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational instruction decoder: opcode and register fields (immediate excluded) to a decodedFields_t.
module decode_fields
  import decode_pkg::*;
#(
  parameter int                 OPC_W     = DEF_OPC_W,
  parameter int                 REG_AW    = DEF_REG_AW,
  parameter logic [OPC_W-1:0]   STORE_OPC = OPC_W'(STORE),
  parameter logic [OPC_W-1:0]   LOAD_OPC  = OPC_W'(LOAD),
  parameter logic [OPC_W-1:0]   NOP_OPC   = OPC_W'(NOP),
  localparam int                HI_W      = OPC_W + 3*REG_AW
) (
  input  logic [HI_W-1:0] opFields,
  output decodedFields_t  fields
);

  logic [OPC_W-1:0]  opc;
  logic [REG_AW-1:0] regA;
  logic [REG_AW-1:0] regB;
  logic [REG_AW-1:0] regC;
  logic              isStore;

  assign opc     = opFields[HI_W-1 -: OPC_W];
  assign regA    = opFields[3*REG_AW-1 -: REG_AW];
  assign regB    = opFields[2*REG_AW-1 -: REG_AW];
  assign regC    = opFields[REG_AW-1:0];
  assign isStore = (opc == STORE_OPC);

  // Stores read the data register from field A, so the operand pair shifts up one field.
  always_comb begin
    fields           = '0;
    fields.raddr1    = DEF_REG_AW'(isStore ? regA : regB);
    fields.raddr2    = DEF_REG_AW'(isStore ? regB : regC);
    fields.dest      = DEF_REG_AW'(regA);
    fields.isLoad    = (opc == LOAD_OPC);
    fields.isStore   = isStore;
    fields.writesReg = !(isStore || (opc == NOP_OPC));
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage with ID/EX register, valid/ready handshake, flush and load-use bubble.
// Define DECODE_HAZARD_EN to enable load-use detection; otherwise the hazard term is tied low.
module decode_stage
  import decode_pkg::*;
#(
  parameter int                 OPC_W     = DEF_OPC_W,
  parameter int                 REG_AW    = DEF_REG_AW,
  parameter logic [OPC_W-1:0]   STORE_OPC = OPC_W'(STORE),
  parameter logic [OPC_W-1:0]   LOAD_OPC  = OPC_W'(LOAD),
  parameter logic [OPC_W-1:0]   NOP_OPC   = OPC_W'(NOP),
  localparam int                INSTR_W   = OPC_W + 4*REG_AW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [REG_AW-1:0]  out_raddr1,
  output logic [REG_AW-1:0]  out_raddr2,
  output logic [REG_AW-1:0]  out_dest,
  output logic               out_is_load,
  output logic               out_is_store,
  output logic               out_writes_reg,
  output logic               hazard_stall
);

  decodedFields_t     inDec;
  logic               hazard;
  logic               capture;
  logic               drain;

  logic               idexValid_p1;
  logic [INSTR_W-1:0] idexInstr_p1;
  logic [REG_AW-1:0]  idexRaddr1_p1;
  logic [REG_AW-1:0]  idexRaddr2_p1;
  logic [REG_AW-1:0]  idexDest_p1;
  logic               idexIsLoad_p1;
  logic               idexIsStore_p1;
  logic               idexWritesReg_p1;

  decode_fields #(
    .OPC_W    (OPC_W),
    .REG_AW   (REG_AW),
    .STORE_OPC(STORE_OPC),
    .LOAD_OPC (LOAD_OPC),
    .NOP_OPC  (NOP_OPC)
  ) uDecode (
    .opFields(in_instr[INSTR_W-1:REG_AW]),
    .fields  (inDec)
  );

`ifdef DECODE_HAZARD_EN
  // Register 0 is a real register here, so it takes part in the comparison.
  assign hazard = idexValid_p1 && idexIsLoad_p1 &&
                  ((idexDest_p1 == REG_AW'(inDec.raddr1)) ||
                   (idexDest_p1 == REG_AW'(inDec.raddr2)));
`else
  assign hazard = 1'b0;
`endif

  assign in_ready     = !flush && !hazard && (!idexValid_p1 || out_ready);
  assign capture      = in_valid && in_ready;
  assign drain        = idexValid_p1 && out_ready;
  assign hazard_stall = in_valid && hazard && !flush;

  // ---- ID/EX register boundary ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idexValid_p1     <= 1'b0;
      idexInstr_p1     <= '0;
      idexRaddr1_p1    <= '0;
      idexRaddr2_p1    <= '0;
      idexDest_p1      <= '0;
      idexIsLoad_p1    <= 1'b0;
      idexIsStore_p1   <= 1'b0;
      idexWritesReg_p1 <= 1'b0;
    end else if (flush || (drain && !capture)) begin
      idexValid_p1     <= 1'b0;
      idexInstr_p1     <= '0;
      idexRaddr1_p1    <= '0;
      idexRaddr2_p1    <= '0;
      idexDest_p1      <= '0;
      idexIsLoad_p1    <= 1'b0;
      idexIsStore_p1   <= 1'b0;
      idexWritesReg_p1 <= 1'b0;
    end else if (capture) begin
      idexValid_p1     <= 1'b1;
      idexInstr_p1     <= in_instr;
      idexRaddr1_p1    <= REG_AW'(inDec.raddr1);
      idexRaddr2_p1    <= REG_AW'(inDec.raddr2);
      idexDest_p1      <= REG_AW'(inDec.dest);
      idexIsLoad_p1    <= inDec.isLoad;
      idexIsStore_p1   <= inDec.isStore;
      idexWritesReg_p1 <= inDec.writesReg;
    end
  end

  assign out_valid      = idexValid_p1;
  assign out_instr      = idexInstr_p1;
  assign out_raddr1     = idexRaddr1_p1;
  assign out_raddr2     = idexRaddr2_p1;
  assign out_dest       = idexDest_p1;
  assign out_is_load    = idexIsLoad_p1;
  assign out_is_store   = idexIsStore_p1;
  assign out_writes_reg = idexWritesReg_p1;

endmodule
